// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice resolved per stage,
// carry registered between stages, with carry/overflow/zero flags and valid/ready flow control.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int unsigned SDIV  = (STAGES < 1) ? 1 : STAGES;
  localparam int unsigned CHUNK = WIDTH / SDIV;

  if ((STAGES < 1) || ((WIDTH % SDIV) != 0)) begin : g_bad_params
    $error("pipelined_addsub: STAGES must be >= 1 and divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ADDC = 2'b01,
    OP_SUB  = 2'b10,
    OP_SUBB = 2'b11
  } op_e;

  op_e              opc;
  logic [WIDTH-1:0] bp;
  logic             c0;
  logic             adv;

  assign opc      = op_e'(op);
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    bp = b;
    c0 = 1'b0;
    case (opc)
      OP_ADD:  begin bp = b;  c0 = 1'b0; end
      OP_ADDC: begin bp = b;  c0 = cin;  end
      OP_SUB:  begin bp = ~b; c0 = 1'b1; end
      OP_SUBB: begin bp = ~b; c0 = cin;  end
      default: ;
    endcase
  end

  // Index s is the input of stage s; index STAGES is the output of the last stage.
  // ia carries finished sum chunks below the current chunk and pending A bits above it.
  logic [WIDTH-1:0] ia [STAGES+1];
  logic [WIDTH-1:0] ib [STAGES];
  logic             ic [STAGES+1];
  logic             iz [STAGES+1];
  logic             iv [STAGES+1];

  assign ia[0] = a;
  assign ib[0] = bp;
  assign ic[0] = c0;
  assign iz[0] = 1'b1;
  assign iv[0] = in_valid;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = s * CHUNK;

    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] ra;
    logic             rc;
    logic             rz;
    logic             rv;

    always_comb begin
      csum  = {1'b0, ia[s][LO +: CHUNK]} + {1'b0, ib[s][LO +: CHUNK]}
            + {{CHUNK{1'b0}}, ic[s]};
      nxt_a = ia[s];
      nxt_a[LO +: CHUNK] = csum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ra <= '0;
        rc <= 1'b0;
        rz <= 1'b0;
        rv <= 1'b0;
      end else if (adv) begin
        ra <= nxt_a;
        rc <= csum[CHUNK];
        rz <= iz[s] & (csum[CHUNK-1:0] == '0);
        rv <= iv[s];
      end
    end

    assign ia[s+1] = ra;
    assign ic[s+1] = rc;
    assign iz[s+1] = rz;
    assign iv[s+1] = rv;

    if (s < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] rb;
      always_ff @(posedge clk) begin
        if (rst)      rb <= '0;
        else if (adv) rb <= ib[s];
      end
      assign ib[s+1] = rb;
    end else begin : g_flags
      logic rovf;
      // Carry into the MSB is a^b^sum at that bit; overflow is it XOR carry out.
      always_ff @(posedge clk) begin
        if (rst)      rovf <= 1'b0;
        else if (adv) rovf <= ia[s][WIDTH-1] ^ ib[s][WIDTH-1] ^ csum[CHUNK-1] ^ csum[CHUNK];
      end
      assign ovf = rovf;
    end
  end

  assign sum       = ia[STAGES];
  assign cout      = ic[STAGES];
  assign zero      = iz[STAGES];
  assign out_valid = iv[STAGES];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed 32-bit/4-stage checks plus 16-bit variants
// with 1, 2 and 16 stages checked against a golden adder model.
module tb_pipelined_addsub;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf, zero;
  logic [1:0]  op;
  logic [31:0] a, b, sum;

  logic        v16, cin16, ordy16;
  logic [1:0]  op16;
  logic [15:0] a16, b16;
  logic        ir16 [3];
  logic        ov16 [3];
  logic        c16  [3];
  logic        o16  [3];
  logic        z16  [3];
  logic [15:0] s16  [3];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned rd16 [3] = '{0, 0, 0};

  typedef struct {
    logic [18:0] r;
    int unsigned cyc;
  } e16_t;
  e16_t eq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  function automatic int unsigned st16(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 16;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_w16
    pipelined_addsub #(.WIDTH(16), .STAGES((k == 0) ? 1 : (k == 1) ? 2 : 16)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16[k]),
      .a(a16), .b(b16), .op(op16), .cin(cin16),
      .out_valid(ov16[k]), .out_ready(ordy16),
      .sum(s16[k]), .cout(c16[k]), .ovf(o16[k]), .zero(z16[k])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [18:0] gold16(input logic [1:0] o, input logic [15:0] x, y,
                                         input logic ci);
    logic [15:0] yp;
    logic        c0;
    logic [16:0] f;
    logic        ov;
    yp = o[1] ? ~y : y;
    c0 = (o == 2'b00) ? 1'b0 : (o == 2'b10) ? 1'b1 : ci;
    f  = {1'b0, x} + {1'b0, yp} + {16'd0, c0};
    ov = (x[15] == yp[15]) && (f[15] != x[15]);
    return {f[15:0], f[16], ov, f[15:0] == 16'h0};
  endfunction

  // One isolated 32-bit operation; entered and left at posedge+1.
  task automatic single(input string tag, input logic [1:0] o, input logic [31:0] x, y,
                        input logic ci, input logic [31:0] es, input logic ec, eo, ez);
    int unsigned lat;
    out_ready = 1'b1; op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd4);
    chk({tag, ".sum"},  64'(sum),  64'(es));
    chk({tag, ".cout"}, 64'(cout), 64'(ec));
    chk({tag, ".ovf"},  64'(ovf),  64'(eo));
    chk({tag, ".zero"}, 64'(zero), 64'(ez));
    @(posedge clk); #1;
  endtask

  task automatic push16(input logic [1:0] o, input logic [15:0] x, y, input logic ci,
                        input logic [18:0] e);
    op16 = o; a16 = x; b16 = y; cin16 = ci; v16 = 1'b1;
    eq.push_back('{e, cyc});
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov16[k] === 1'b1) begin
        if (rd16[k] >= eq.size()) begin
          chk($sformatf("w16s%0d.extra_valid", st16(k)), 64'(ov16[k]), 64'd0);
        end else begin
          chk($sformatf("w16s%0d.result#%0d", st16(k), rd16[k]),
              64'({s16[k], c16[k], o16[k], z16[k]}), 64'(eq[rd16[k]].r));
          chk($sformatf("w16s%0d.latency#%0d", st16(k), rd16[k]),
              64'(cyc - eq[rd16[k]].cyc), 64'(st16(k)));
        end
        rd16[k]++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic        stalled_prev;
    int unsigned rx, tx, seen;
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    logic        rc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
    v16 = 1'b0; ordy16 = 1'b1; op16 = 2'b00; a16 = '0; b16 = '0; cin16 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.sum",       64'(sum),       64'd0);
    chk("reset.flags",     64'({cout, ovf, zero}), 64'd0);
    chk("reset.in_ready",  64'(in_ready),  64'd1);
    chk("reset.w16",       64'({ov16[0], ov16[1], ov16[2], s16[2]}), 64'd0);

    single("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    single("add_ovf",  2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    single("sub_ovf",  2'b10, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    single("sub_brw",  2'b10, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    single("addc",     2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    single("subb",     2'b11, 32'h0000_0003, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

    // 8 back-to-back ops, each 0x00FFFFFF + (i+1) = 0x01000000 + i; sink stalls in cycles 6..8.
    rx = 0; tx = 0; stalled_prev = 1'b0; held = '0;
    for (int j = 0; j < 24; j++) begin
      out_ready = !(j >= 6 && j <= 8);
      if (tx < 8) begin
        in_valid = 1'b1; op = 2'b00; a = 32'h00FF_FFFF; b = 32'(tx + 1); cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk($sformatf("stream.in_ready@%0d", j), 64'(in_ready), 64'(!(j >= 6 && j <= 8)));
      if (stalled_prev) begin
        chk($sformatf("stream.hold_valid@%0d", j), 64'(out_valid), 64'd1);
        chk($sformatf("stream.hold_sum@%0d", j),   64'(sum),       64'(held));
      end
      if (out_valid && out_ready) begin
        if (rx < 8) chk($sformatf("stream.sum#%0d", rx), 64'(sum), 64'(32'h0100_0000 + rx));
        else        chk("stream.extra_valid", 64'(out_valid), 64'd0);
        rx++;
      end
      stalled_prev = out_valid && !out_ready;
      held = sum;
      if (in_valid && in_ready) tx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream.count", 64'(rx), 64'd8);

    // Three ops in flight, then a one-cycle reset.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = 2'b00; a = 32'hAAAA_0000 + 32'(i); b = 32'h1; cin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.sum",       64'(sum),       64'd0);
    chk("rst.flags",     64'({cout, ovf, zero}), 64'd0);
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("rst.ghost", 64'(seen), 64'd0);
    single("post_rst", 2'b00, 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);

    // 16-bit variants: hand-computed corner vectors, then golden-model random traffic.
    push16(2'b00, 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
    push16(2'b00, 16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0});
    push16(2'b10, 16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b1, 1'b1, 1'b0});
    push16(2'b10, 16'h0005, 16'h0007, 1'b0, {16'hFFFE, 1'b0, 1'b0, 1'b0});
    push16(2'b01, 16'hFFFF, 16'h0000, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1});
    push16(2'b11, 16'h0003, 16'h0001, 1'b0, {16'h0001, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 10000; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? 16'h8000 - 16'($urandom_range(0, 1)) : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'hFFFF * 16'($urandom_range(0, 1)) : 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        v16 = 1'b0;
        @(posedge clk); #1;
      end
      chk("w16.in_ready", 64'({ir16[0], ir16[1], ir16[2]}), 64'd7);
      push16(ro, ra, rb, rc, gold16(ro, ra, rb, rc));
    end
    v16 = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("w16s%0d.count", st16(k)), 64'(rd16[k]), 64'(eq.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parameterised, pipelined integer adder/subtractor; next generation of the 32-bit ripple-carry adder.
- Splits a WIDTH-bit operation into STAGES equal chunks. One chunk is resolved per clock, with the carry registered between stages.
- Produces carry, signed-overflow and zero flags for the ALU/EX stage.
- Uses a valid/ready handshake with back-pressure, so the EX stage can stall it.

Parameters:
- WIDTH, 32: operand/result width in bits.
- STAGES, 4: pipeline depth. Must be ≥1 and divide WIDTH exactly (CHUNK = WIDTH/STAGES). Any other value is an elaboration error.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: operands and op are valid.
- in_ready, output, 1: block can accept an operation this cycle.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- op, input, 2: operation select. 00 ADD, 01 ADDC, 10 SUB, 11 SUBB.
- cin, input, 1: carry-in, used by ADDC/SUBB only.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- sum, output, WIDTH: result.
- cout, output, 1: raw carry out of the MSB (for SUB/SUBB, 1 = no borrow).
- ovf, output, 1: signed two's-complement overflow.
- zero, output, 1: sum == 0.

Behaviour:
- Clocking: one clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, zero=0. All internal valid bits, carries and skew registers are also cleared. in_ready=1 during the cycle after reset.
- Operand preparation, combinational at input:
  - B' = b for ADD/ADDC; B' = ~b for SUB/SUBB.
  - c0 = 0 for ADD, cin for ADDC, 1 for SUB, cin for SUBB.
- Global advance enable: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - An operation is accepted on an edge where in_valid & in_ready.
  - When adv=0, every stage register holds its value (full-pipeline stall, no bubble collapsing).
- Stage s (0..STAGES-1):
  - Adds chunk s of A and B' plus the incoming carry (c0 for s=0; the registered carry of stage s-1 otherwise).
  - Registers the sum chunk, carry-out and a valid bit.
  - Upper, not-yet-summed chunks of A and B' are delayed alongside (operand skew). Already-computed lower sum chunks are delayed to align at the output (result de-skew).
  - Bubbles (valid=0) propagate when adv=1. Invalid stages still clock data, but their contents are don't-care.
- Latency: an operation accepted on edge k has out_valid=1 in the cycle after edge k+STAGES-1, i.e. STAGES cycles.
- Throughput: 1 operation/cycle while out_ready=1.
- STAGES=1 degenerates to a single registered WIDTH-bit adder with latency 1.
- Flags, computed in the final stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - zero = AND of per-chunk zero bits accumulated through the stages.
- Output holding: sum/cout/ovf/zero hold stable while out_valid=1 and out_ready=0. They change only on an edge with adv=1.
- Simultaneous events:
  - Accept at input and drain at output on the same edge with out_ready=1: both occur, no loss.
  - in_valid=1 while in_ready=0: not accepted. The source must hold its inputs, and the block does not sample them.
- Reset mid-operation: every in-flight operation is discarded. out_valid=0 on the next cycle, and no partial result ever appears.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- ADD a=0xFFFFFFFF, b=0x00000001 → after 4 cycles: sum=0x00000000, cout=1, ovf=0, zero=1.
- ADD a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, cout=0, ovf=1, zero=0. SUB a=0x80000000, b=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
- SUB a=5, b=7 → sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. Then ADDC a=0xFFFFFFFF, b=0, cin=1 → sum=0, cout=1, zero=1. Then SUBB a=3, b=1, cin=0 → sum=1.
- Stream 8 back-to-back operations with out_ready held low for 3 cycles mid-stream:
  - in_ready drops in the same cycles that out_valid=1 & out_ready=0.
  - Outputs stay frozen while stalled.
  - All 8 results arrive in order with no duplicates.
- Assert rst for 1 cycle with 3 operations in flight:
  - out_valid=0 and all outputs 0 the following cycle.
  - None of the 3 results ever appears.
  - A new ADD 2+3 accepted after reset yields sum=5.
- Repeat the first three tests with WIDTH=16 and STAGES ∈ {1, 2, 16}. Latency must equal STAGES, and results must match a golden model over 10k random operations.
